// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state encoding, shared types and round functions.
package sha256_pkg;
  typedef logic [0:7][31:0] hv_t;
  typedef logic [0:15][31:0] wb_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;
  localparam hv_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round over working words a..h (index 0..7).
module sha256_round
  import sha256_pkg::*;
(
  input  hv_t         s_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output hv_t         s_o
);
  logic [31:0] t1, t2;
  assign t1 = s_i[7] + bsig1(s_i[4]) + ch(s_i[4], s_i[5], s_i[6]) + k_i + w_i;
  assign t2 = bsig0(s_i[0]) + maj(s_i[0], s_i[1], s_i[2]);
  assign s_o = {t1 + t2, s_i[0], s_i[1], s_i[2], s_i[3] + t1, s_i[4], s_i[5], s_i[6]};
endmodule

// File: rtl/sha256_compress_iter.sv
// sha256_compress_iter: iterative SHA-256 block compression, ROUNDS_PER_CYCLE rounds per clock.
module sha256_compress_iter
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         use_iv,
  input  logic [255:0] prev_hash,
  input  logic [511:0] block,
  output logic         ready,
  output logic         hash_complete,
  output logic [255:0] updated_hash
);
  localparam logic [5:0] STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST = 6'(64 - ROUNDS_PER_CYCLE);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic done_q, done_d;
  hv_t hash_q, hash_d, h_q, h_d, s_q, s_d, cv;
  wb_t w_q, w_d;
  hv_t s_chain [0:ROUNDS_PER_CYCLE];
  wb_t w_chain [0:ROUNDS_PER_CYCLE];
  assign s_chain[0] = s_q;
  assign w_chain[0] = w_q;
  // Round chain and schedule window advance together, one word per round.
  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_r
    sha256_round u_round (
      .s_i(s_chain[r]),
      .k_i(K[cnt_q + 6'(r)]),
      .w_i(w_chain[r][0]),
      .s_o(s_chain[r+1])
    );
    assign w_chain[r+1] = {w_chain[r][1:15],
      ssig1(w_chain[r][14]) + w_chain[r][9] + ssig0(w_chain[r][1]) + w_chain[r][0]};
  end
  assign cv = use_iv ? IV : hv_t'(prev_hash);
  assign ready = state_q == S_IDLE;
  assign hash_complete = done_q;
  assign updated_hash = hash_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    hash_d = hash_q;
    h_d = h_q;
    s_d = s_q;
    w_d = w_q;
    case (state_q)
      S_IDLE: if (start) begin
        h_d = cv;
        s_d = cv;
        w_d = wb_t'(block);
        cnt_d = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        s_d = s_chain[ROUNDS_PER_CYCLE];
        w_d = w_chain[ROUNDS_PER_CYCLE];
        cnt_d = cnt_q + STEP;
        state_d = (cnt_q == LAST) ? S_FINAL : S_ROUND;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) hash_d[i] = h_q[i] + s_q[i];
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      hash_q <= '0;
      h_q <= '0;
      s_q <= '0;
      w_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      hash_q <= hash_d;
      h_q <= h_d;
      s_q <= s_d;
      w_q <= w_d;
    end
  end
endmodule

// File: tb/tb_sha256_compress_iter.sv
// tb_sha256_compress_iter: four engines (1/2/4/8 rounds per clock) against a scoreboard and reference model.
module tb_sha256_compress_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, use_iv = 1'b0;
  logic [3:0] st = '0;
  logic [511:0] blk = '0;
  logic [255:0] prev = '0;
  logic [3:0] rdy, hc;
  logic [255:0] uh [4];
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {logic [255:0] d; int due;} exp_t;
  exp_t q [4][$];
  logic [31:0] kt [64];
  logic [255:0] ivr;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
    32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  for (genvar j = 0; j < 4; j++) begin : g_dut
    sha256_compress_iter #(.ROUNDS_PER_CYCLE(1 << j)) u_dut (
      .clock(clk), .reset(rst), .start(st[j]), .use_iv(use_iv), .prev_hash(prev),
      .block(blk), .ready(rdy[j]), .hash_complete(hc[j]), .updated_hash(uh[j]));
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule computed up front, then 64 rounds.
  function automatic logic [255:0] ref_compress(input logic [255:0] cv, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = cv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = cv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk)
    for (int j = 0; j < 4; j++)
      if (hc[j]) begin
        if (q[j].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_complete[%0d]: got pulse expected none", j);
        end else begin
          exp_t e;
          e = q[j].pop_front();
          chk($sformatf("digest[%0d]", j), uh[j], e.d);
          chk($sformatf("latency[%0d]", j), 256'(cyc), 256'(e.due));
        end
      end

  task automatic wait_ready(input logic [3:0] m);
    int n = 0;
    @(negedge clk);
    while ((rdy & m) != m && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((rdy & m) != m) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got %b expected mask %b", rdy, m);
    end
  endtask

  task automatic issue(input logic [3:0] m, input logic [511:0] b, input logic iv,
                       input logic [255:0] p, input logic [255:0] e);
    st = m;
    blk = b;
    use_iv = iv;
    prev = p;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) if (m[j]) q[j].push_back('{e, cyc + (64 >> j) + 1});
    st = '0;
  endtask

  initial begin
    int p, np, n;
    logic prime;
    real c;
    logic [511:0] rb;
    logic [255:0] rp, r1;
    logic ri;
    // Round constants and IV from the cube/square roots of the first primes.
    p = 2;
    np = 0;
    while (np < 64) begin
      prime = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) prime = 1'b0;
      if (prime) begin
        c = real'(p) ** (1.0 / 3.0);
        kt[np] = 32'(longint'($floor((c - $floor(c)) * 4294967296.0)));
        if (np < 8) begin
          c = $sqrt(real'(p));
          ivr[255 - 32*np -: 32] = 32'(longint'($floor((c - $floor(c)) * 4294967296.0)));
        end
        np++;
      end
      p++;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("reset_ready[%0d]", j), 256'(rdy[j]), 256'(1));
      chk($sformatf("reset_complete[%0d]", j), 256'(hc[j]), 256'(0));
      chk($sformatf("reset_hash[%0d]", j), uh[j], 256'(0));
    end
    wait_ready(4'hf);
    issue(4'hf, ABC, 1'b1, '0, D_ABC);
    wait_ready(4'hf);
    issue(4'hf, EMPTY, 1'b1, {8{32'hdeadbeef}}, D_EMPTY);
    // Two-block message, second block accepted in the completion cycle of the first.
    wait_ready(4'hf);
    r1 = ref_compress(ivr, B1);
    issue(4'h1, B1, 1'b1, '0, r1);
    n = 0;
    do @(negedge clk); while (!hc[0] && n++ < 100);
    chk("complete_seen", 256'(hc[0]), 256'(1));
    chk("ready_in_complete", 256'(rdy[0]), 256'(1));
    issue(4'h1, B2, 1'b0, r1, D_TWO);
    // Start while busy must be ignored.
    wait_ready(4'hf);
    issue(4'hf, ABC, 1'b1, '0, D_ABC);
    repeat (2) @(negedge clk);
    chk("busy_ready", 256'(rdy), 256'(0));
    for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
    st = 4'hf;
    blk = rb;
    use_iv = 1'b0;
    prev = {8{32'h01234567}};
    @(posedge clk);
    #1 st = '0;
    // Reset mid-block on the one-round engine.
    wait_ready(4'hf);
    issue(4'h1, ABC, 1'b1, '0, D_ABC);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q[0].delete();
    @(negedge clk);
    chk("abort_ready", 256'(rdy), 256'(4'hf));
    chk("abort_complete", 256'(hc), 256'(0));
    chk("abort_hash", uh[0], 256'(0));
    repeat (80) @(negedge clk);
    wait_ready(4'hf);
    issue(4'hf, ABC, 1'b1, '0, D_ABC);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) rp[32*i +: 32] = $urandom;
      ri = 1'($urandom_range(1));
      wait_ready(4'hf);
      issue(4'hf, rb, ri, rp, ref_compress(ri ? ivr : rp, rb));
    end
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    for (int j = 0; j < 4; j++)
      if (q[j].size() != 0) begin
        tests++;
        fails++;
        $display("FAIL drain[%0d]: got %0d pending expected 0", j, q[j].size());
      end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_compress_iter.md
# sha256_compress_iter

Iterative, parametrised SHA-256 compression engine. Accepts one 512-bit message block plus a chaining value and expands the message schedule on the fly. Runs the 64 rounds over 64/ROUNDS_PER_CYCLE clocks, performs the final feed-forward addition and returns the 256-bit updated hash under a start/ready/complete handshake. Sits between the message padder/block formatter and the digest output stage, and supersedes the single-round hash process datapath.

## Interface
- ROUNDS_PER_CYCLE, 1: rounds unrolled per clock; legal values are 1, 2, 4 and 8 (must divide 64).
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  request to compress one block; accepted only when `ready`=1.
- use_iv  input  1  sampled with `start`:
  - 1: chaining value = the SHA-256 IV.
  - 0: chaining value = `prev_hash`.
- prev_hash  input  256  chaining value; word H0 at [255:224], H7 at [31:0].
- block  input  512  message block; word W0 at [511:480], W15 at [31:0].
- ready  output  1  engine idle; a `start` is accepted this cycle.
- hash_complete  output  1  one-cycle pulse: `updated_hash` is newly valid.
- updated_hash  output  256  result, same word order as `prev_hash`; held until the next completion.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE:
  - `ready`=1.
  - On `start` the block captures `block` into a 16-word schedule window.
  - It captures the selected chaining value into H0..H7 and into working registers a..h.
  - It clears the round counter and moves to ROUND.
- ROUND:
  - Each cycle applies ROUNDS_PER_CYCLE chained rounds to a..h.
  - For round t, W_t is window word 0.
  - Per round the window shifts by one word and appends σ1(w14)+w9+σ0(w1)+w0, mod 2^32.
  - Round arithmetic:
    - T1 = h+Σ1(e)+Ch(e,f,g)+K_t+W_t
    - T2 = Σ0(a)+Maj(a,b,c)
    - e' = d+T1, a' = T1+T2
    - remaining registers shift: b'=a, c'=b, d'=c, f'=e, g'=f, h'=g.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - Every add is modulo 2^32; carries are discarded.
  - The counter advances by ROUNDS_PER_CYCLE. After the cycle that completes round 63, the state moves to FINAL.
- FINAL:
  - `updated_hash` word i = Hi + working word i, mod 2^32.
  - `hash_complete` is set to 1; state moves to IDLE.
- `start` while `ready`=0 is ignored. Inputs are sampled only at acceptance, so upstream may change them afterwards.
- Reset:
  - Values: state IDLE, `ready`=1, `hash_complete`=0, `updated_hash`=0, counter 0.
  - Reset mid-operation aborts the block with no completion pulse.
  - Reset wins over a simultaneous `start`.

## Timing
- `start` is accepted at edge E0.
- `ready` is low from after E0 until after edge E(N+1), where N = 64/ROUNDS_PER_CYCLE.
- `hash_complete` is high in the cycle following E(N+1): latency N+1 clocks (65, 33, 17, 9).
- `hash_complete` is high for exactly one cycle, and `ready` is already 1 in that cycle. A `start` there is accepted, giving back-to-back throughput of one block per N+1 clocks.
- `updated_hash` changes only on the FINAL edge.

## Structure
- Package sha256_pkg holds:
  - K[0:63] constant table;
  - IV constants 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19;
  - state enum typedef;
  - pure functions Σ0, Σ1, σ0, σ1, Ch, Maj.
- Sub-module sha256_round: purely combinational single round, taking {a..h, K_t, W_t} and producing {a'..h'}. It is instantiated ROUNDS_PER_CYCLE times in a generate chain.
- The schedule expansion is unrolled alongside the round chain.

## Test plan
- "abc" padded block, use_iv=1, RPC=1 -> `hash_complete` 65 cycles after acceptance. `updated_hash` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message padded block, use_iv=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefg…nopq" (448 bits): block 1 with use_iv=1, then block 2 with use_iv=0 and prev_hash = block-1 result, started in the `hash_complete` cycle -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Repeat "abc" at RPC=2, 4 and 8 -> identical digest; latency 33, 17 and 9 cycles.
- Pulse `start` with different data while busy -> ignored; the original digest is produced.
- Assert `reset` at round 30 -> no `hash_complete`, `updated_hash`=0, `ready`=1 on the next cycle. A following "abc" run yields the correct digest.
